// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side bus for mem_arbiter.
// The arbiter sits on the slave modport; the requester/memory environment sits on master.
interface mem_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [10:0] req0_addr_i;
  logic        req0_we_i;
  logic [3:0]  req0_be_i;
  logic [31:0] req0_wdata_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [10:0] req1_addr_i;
  logic        req1_we_i;
  logic [3:0]  req1_be_i;
  logic [31:0] req1_wdata_i;

  logic        rsp0_valid_o;
  logic [31:0] rsp0_rdata_o;
  logic        rsp0_err_o;
  logic        rsp1_valid_o;
  logic [31:0] rsp1_rdata_o;
  logic        rsp1_err_o;

  logic [10:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_bytemask_o;
  logic        mem_write_en_o;
  logic        mem_read_en_o;
  logic [31:0] mem_rd_data_i;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_we_i, req0_be_i, req0_wdata_i,
    input  req1_valid_i, req1_addr_i, req1_we_i, req1_be_i, req1_wdata_i,
    input  mem_rd_data_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    output rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    output mem_addr_o, mem_wr_data_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_we_i, req0_be_i, req0_wdata_i,
    output req1_valid_i, req1_addr_i, req1_we_i, req1_be_i, req1_wdata_i,
    output mem_rd_data_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_rdata_o, rsp0_err_o,
    input  rsp1_valid_o, rsp1_rdata_o, rsp1_err_o,
    input  mem_addr_o, mem_wr_data_o, mem_bytemask_o, mem_write_en_o, mem_read_en_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto a single registered-read memory.
// One transfer per cycle; each transfer yields a one-cycle response pulse one cycle later.
module mem_arbiter #(
  parameter int unsigned NPORTS = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } last_grant_e;

  last_grant_e       last_grant_q, last_grant_d;
  logic [NPORTS-1:0] rsp_pending_q, rsp_pending_d;
  logic              rsp_is_read_q, rsp_is_read_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NPORTS-1:0] gnt;
  logic              xfer;
  logic              misaligned;
  logic [10:0]       sel_addr;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;

  // A tie goes to the port that did not win the last transfer.
  always_comb begin
    gnt = '0;
    if (!rst_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        if (last_grant_q == LAST_P1) gnt[0] = 1'b1;
        else                         gnt[1] = 1'b1;
      end else begin
        gnt[0] = bus.req0_valid_i;
        gnt[1] = bus.req1_valid_i;
      end
    end
  end

  assign bus.req0_ready_o = gnt[0];
  assign bus.req1_ready_o = gnt[1];
  assign xfer             = |gnt;

  always_comb begin
    sel_addr  = bus.req0_addr_i;
    sel_we    = bus.req0_we_i;
    sel_be    = bus.req0_be_i;
    sel_wdata = bus.req0_wdata_i;
    if (gnt[1]) begin
      sel_addr  = bus.req1_addr_i;
      sel_we    = bus.req1_we_i;
      sel_be    = bus.req1_be_i;
      sel_wdata = bus.req1_wdata_i;
    end
  end

  assign misaligned = (sel_addr[1:0] != 2'b00);

  always_comb begin
    bus.mem_addr_o     = '0;
    bus.mem_wr_data_o  = '0;
    bus.mem_bytemask_o = '0;
    bus.mem_write_en_o = 1'b0;
    bus.mem_read_en_o  = 1'b0;
    if (xfer && !misaligned) begin
      bus.mem_addr_o     = sel_addr;
      bus.mem_wr_data_o  = sel_wdata;
      bus.mem_bytemask_o = sel_be;
      bus.mem_write_en_o = sel_we;
      bus.mem_read_en_o  = !sel_we;
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    rsp_pending_d = gnt;
    rsp_is_read_d = xfer && !sel_we && !misaligned;
    rsp_err_d     = xfer && misaligned;
    if (xfer) last_grant_d = gnt[1] ? LAST_P1 : LAST_P0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q  <= LAST_P1;
      rsp_pending_q <= '0;
      rsp_is_read_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_is_read_q <= rsp_is_read_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Read data is taken straight from the registered memory output in the response cycle.
  assign bus.rsp0_valid_o = rsp_pending_q[0];
  assign bus.rsp1_valid_o = rsp_pending_q[1];
  assign bus.rsp0_rdata_o = (rsp_pending_q[0] && rsp_is_read_q) ? bus.mem_rd_data_i : '0;
  assign bus.rsp1_rdata_o = (rsp_pending_q[1] && rsp_is_read_q) ? bus.mem_rd_data_i : '0;
  assign bus.rsp0_err_o   = rsp_pending_q[0] && rsp_err_q;
  assign bus.rsp1_err_o   = rsp_pending_q[1] && rsp_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one parameter: NPORTS, default 2, the number of requester ports; only the value 2 is supported.
REQ-002 clk_i  input  1  sole clock, rising-edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 reqN_valid_i  input  1  request N valid, for N in {0,1}.
REQ-005 reqN_ready_o  output  1  request N accepted this cycle.
REQ-006 reqN_addr_i  input  11  byte address.
REQ-007 reqN_we_i  input  1  1 = write, 0 = read.
REQ-008 reqN_be_i  input  4  byte enables, bit i = wdata[8i+7:8i].
REQ-009 reqN_wdata_i  input  32  write data.
REQ-010 rspN_valid_o  output  1  one-cycle response pulse.
REQ-011 rspN_rdata_o  output  32  read data, qualified by rspN_valid_o.
REQ-012 rspN_err_o  output  1  misaligned-access error, qualified by rspN_valid_o.
REQ-013 mem_addr_o  output  11  memory address.
REQ-014 mem_wr_data_o  output  32  memory write data.
REQ-015 mem_bytemask_o  output  4  memory byte mask.
REQ-016 mem_write_en_o  output  1  memory write strobe.
REQ-017 mem_read_en_o  output  1  memory read strobe.
REQ-018 mem_rd_data_i  input  32  memory read data, valid one cycle after the read strobe (registered read).

Function
REQ-019 Handshake: a request SHALL transfer in the cycle where reqN_valid_i and reqN_ready_o are both 1; requesters hold valid, addr, we, be and wdata stable until transfer; ready SHALL be combinational from valid and the arbitration state.
REQ-020 At most one port SHALL get ready per cycle; if exactly one port is valid, it SHALL be granted in that cycle.
REQ-021 If both ports are valid, the port not granted most recently SHALL win (round-robin); the last_grant register SHALL update only on a transfer.
REQ-022 The arbiter SHALL accept one transfer every cycle; no idle cycle is needed between back-to-back transfers, from the same port or alternating ports.
REQ-023 On a transfer with addr[1:0]==0, the arbiter SHALL drive the winner's addr, wdata and be onto mem_* in that same cycle.
- Read: mem_read_en_o=1, mem_write_en_o=0.
- Write: mem_write_en_o=1, mem_read_en_o=0.
REQ-024 A transfer with addr[1:0]!=0 SHALL be misaligned: it asserts no memory strobe, and its response SHALL carry err=1 and rdata=0.
REQ-025 With no transfer in a cycle, both memory strobes SHALL be 0 and mem_addr_o, mem_wr_data_o and mem_bytemask_o SHALL be 0.
REQ-026 Each transfer SHALL produce exactly one rspN_valid_o pulse, on port N only, exactly one cycle after the transfer (latency 1).
REQ-027 Response payload:
- Aligned read: rdata = mem_rd_data_i in the response cycle, err=0.
- Write: rdata=0, err=0.
REQ-028 When rspN_valid_o=0, rspN_rdata_o and rspN_err_o SHALL be 0.
REQ-029 A read following a write to the same address in the next cycle SHALL return the written data; any read-during-write in the same cycle is impossible because only one transfer issues per cycle.
REQ-030 Internal state SHALL be: last_grant (1 bit), rsp_pending[1:0] and rsp_is_read / rsp_err flags, all registered.

Reset
REQ-031 While rst_i=1, the module SHALL hold: all rsp*_valid_o=0, rdata=0, err=0, all mem strobes=0, all ready=0, and last_grant=1 so that port 0 wins the first tie.
REQ-032 Reset asserted in the cycle after a transfer SHALL suppress that transfer's response.
REQ-033 The first transfer SHALL be accepted in the first rising edge after rst_i falls.

Verification
REQ-034 After reset, both ports read addr 0x000 together -> port0 is granted in cycle 0 and port1 in cycle 1; rsp0 arrives in cycle 1 and rsp1 in cycle 2, each with the memory word.
REQ-035 Port0 writes 0xDEADBEEF to 0x010 with be=4'b0011, port0 then reads 0x010 the next cycle, memory preloaded 0x11223344 -> rdata=0x1122BEEF, err=0.
REQ-036 Both ports continuously valid for 8 cycles -> grants alternate 0,1,0,1,...; 8 responses in total, none dropped or duplicated.
REQ-037 Port1 reads 0x013 -> ready=1, no memory strobe; next cycle rsp1_valid=1, err=1, rdata=0.
REQ-038 Reset pulsed in the cycle after a port0 read transfer -> rsp0_valid stays 0; the next tie after reset goes to port0.
